// File: rtl/vec_mem_responder.sv
// Data-memory responder for the 8-bit multicycle datapath: single-byte load/store
// plus 4-beat vector bursts sequenced here, with the write-beat index exported.
module vec_mem_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int BEATS  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic              vec,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic [1:0]        wbeat
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] VRD  = 2'd1;
  localparam logic [1:0] VWR  = 2'd2;

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);
  localparam int         DEPTH     = 2 ** ADDR_W;

  logic [1:0]        state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_wen;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] burst_addr;

  // Burst addresses wrap modulo the array size through natural overflow.
  assign burst_addr = base_q + {{(ADDR_W-2){1'b0}}, beat_q};

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    base_d    = base_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    mem_wen   = 1'b0;
    mem_waddr = addr;
    mem_wdata = wdata;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (we) begin
            mem_wen = 1'b1;
          end else begin
            rdata_d  = mem_q[addr];
            rvalid_d = 1'b1;
          end
          if (vec) begin
            base_d  = addr;
            beat_d  = 2'd1;
            state_d = we ? VWR : VRD;
          end
        end
      end

      VRD: begin
        rdata_d  = mem_q[burst_addr];
        rvalid_d = 1'b1;
        beat_d   = beat_q + 2'd1;
        if (beat_q == LAST_BEAT) begin
          beat_d  = 2'd0;
          state_d = IDLE;
        end
      end

      VWR: begin
        mem_wen   = 1'b1;
        mem_waddr = burst_addr;
        beat_d    = beat_q + 2'd1;
        if (beat_q == LAST_BEAT) begin
          beat_d  = 2'd0;
          state_d = IDLE;
        end
      end

      default: begin
        beat_d  = 2'd0;
        state_d = IDLE;
      end
    endcase

    // An asserted reset aborts a burst: no further beats may land in the array.
    if (reset) begin
      mem_wen = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      beat_q   <= 2'd0;
      base_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      base_q   <= base_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_wen) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign busy   = (state_q != IDLE);
  assign wbeat  = (state_q == VWR) ? beat_q : 2'd0;

endmodule
